// File: rtl/vga_plot_arbiter_if.sv
// Request/grant bundle shared between the drawing engines and the plot arbiter.
// Per-requester fields are packed side by side; requester i occupies slice i.
interface vga_plot_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   lock;
    logic [8*N_REQ-1:0] req_x;
    logic [7*N_REQ-1:0] req_y;
    logic [3*N_REQ-1:0] req_colour;
    logic [N_REQ-1:0]   gnt;

    modport master (
        output req, lock, req_x, req_y, req_colour,
        input  gnt
    );

    modport slave (
        input  req, lock, req_x, req_y, req_colour,
        output gnt
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one VGA pixel-write port among N_REQ drawing
// engines. Optional per-owner lock holds the port for bursts; off-screen
// pixels are granted and consumed but not plotted, and are counted.
module vga_plot_arbiter #(
    parameter int N_REQ = 3,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_plot_arbiter_if.slave    bus,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_colour,
    output logic                 vga_plot,
    output logic [15:0]          clip_count,
    output logic                 idle
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NR = N_REQ;
    localparam int unsigned XL = X_MAX;
    localparam int unsigned YL = Y_MAX;
    localparam logic [OW-1:0] OWNER_RST = OW'(N_REQ - 1);

    logic [OW-1:0]    owner;
    logic [OW-1:0]    sel_idx;
    logic [OW-1:0]    cand;
    logic             sel_valid;
    logic [N_REQ-1:0] gnt_vec;
    logic [7:0]       sel_x;
    logic [6:0]       sel_y;
    logic [2:0]       sel_colour;
    logic             in_range;

    // Grant selection: locked owner keeps the port, else scan from owner+1.
    always_comb begin
        gnt_vec   = '0;
        sel_idx   = owner;
        sel_valid = 1'b0;
        cand      = '0;
        if (!rst) begin
            if (bus.req[owner] && bus.lock[owner]) begin
                sel_idx   = owner;
                sel_valid = 1'b1;
            end else begin
                for (int unsigned k = 1; k <= NR; k++) begin
                    cand = OW'((32'(owner) + k) % NR);
                    if (!sel_valid && bus.req[cand]) begin
                        sel_idx   = cand;
                        sel_valid = 1'b1;
                    end
                end
            end
            if (sel_valid) begin
                gnt_vec[sel_idx] = 1'b1;
            end
        end
    end

    // Pixel mux: pick the granted requester's coordinates and colour.
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (gnt_vec[i]) begin
                sel_x      = bus.req_x[8*i +: 8];
                sel_y      = bus.req_y[7*i +: 7];
                sel_colour = bus.req_colour[3*i +: 3];
            end
        end
        in_range = (32'(sel_x) < XL) && (32'(sel_y) < YL);
    end

    // Consume the granted pixel: advance owner, load output register, count clips.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWNER_RST;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            clip_count <= '0;
        end else if (sel_valid) begin
            owner      <= sel_idx;
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
            vga_plot   <= in_range;
            if (!in_range && clip_count != '1) begin
                clip_count <= clip_count + 16'd1;
            end
        end else begin
            vga_plot <= 1'b0;
        end
    end

    assign bus.gnt = gnt_vec;
    assign idle    = (bus.req == '0) && !vga_plot;
endmodule
